// File: rtl/jtcps_busarb.sv
// jtcps_busarb: round-robin bus arbiter for the CPS DMA/video requesters.
// Requests bus ownership from the main 68000 through busreq/busack, or skips
// that handshake in turbo mode. Grants one requester at a time and inserts a
// gnt=0 gap cycle between owners. A watchdog flags a CPU that never acks.
module jtcps_busarb #(
  parameter int CH = 2,   // number of DMA requesters (1..8)
  parameter int TW = 10   // watchdog width; times out after 2^TW-1 REQ cycles
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          turbo,
  input  logic [CH-1:0] req,
  output logic [CH-1:0] gnt,
  output logic          cpu_busreq,
  input  logic          cpu_busack,
  output logic          busy,
  output logic          timeout_err
);

  localparam int LW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] GRANT   = 3'd2;
  localparam logic [2:0] GAP     = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  // wdog counts completed REQ cycles; when it sits at 2^TW-2 the current
  // cycle is the (2^TW-1)-th one without an ack, so the timeout fires here.
  localparam logic [TW-1:0] WD_LAST = {{(TW-1){1'b1}}, 1'b0};

  logic [2:0]    state_reg,  state_next;
  logic [LW-1:0] last_reg,   last_next;
  logic          tmode_reg,  tmode_next;
  logic [TW-1:0] wdog_reg,   wdog_next;
  logic [CH-1:0] gnt_reg,    gnt_next;
  logic          busreq_reg, busreq_next;
  logic          busy_reg,   busy_next;
  logic          terr_reg,   terr_next;

  logic          win_found;
  logic [LW-1:0] win_idx;
  logic [CH-1:0] win_onehot;

  // Round-robin search: first set request starting at last+1, wrapping.
  // Offsets are scanned from the farthest down to 1 so the nearest wins.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = CH; i >= 1; i--) begin
      idx = int'(last_reg) + i;
      if (idx >= CH) idx = idx - CH;
      if (req[LW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = LW'(idx);
      end
    end
  end

  // One-hot decode of the winning index.
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_idx == LW'(gi));
    end
  endgenerate

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_next  = state_reg;
    last_next   = last_reg;
    tmode_next  = tmode_reg;
    wdog_next   = wdog_reg;
    gnt_next    = gnt_reg;
    busreq_next = busreq_reg;
    terr_next   = terr_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          if (turbo) begin
            tmode_next = 1'b1;
            state_next = GAP;
          end else begin
            tmode_next  = 1'b0;
            busreq_next = 1'b1;
            state_next  = REQ;
          end
        end
      end
      REQ: begin
        if (cpu_busack) begin
          wdog_next  = '0;
          state_next = GAP;
        end else if (wdog_reg == WD_LAST) begin
          terr_next   = 1'b1;
          busreq_next = 1'b0;
          wdog_next   = '0;
          state_next  = RELEASE;
        end else begin
          wdog_next = wdog_reg + 1'b1;
        end
      end
      GAP: begin
        gnt_next = '0;
        if (win_found) begin
          gnt_next   = win_onehot;
          last_next  = win_idx;
          state_next = GRANT;
        end else if (tmode_reg) begin
          state_next = IDLE;
        end else begin
          busreq_next = 1'b0;
          state_next  = RELEASE;
        end
      end
      GRANT: begin
        // The current owner keeps the bus until it drops its own request.
        if (!req[last_reg]) begin
          gnt_next   = '0;
          state_next = GAP;
        end
      end
      RELEASE: begin
        busreq_next = 1'b0;
        if (!cpu_busack) state_next = IDLE;
      end
      default: begin
        gnt_next    = '0;
        busreq_next = 1'b0;
        state_next  = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // State and registered outputs; reset returns everything to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      last_reg   <= LW'(CH - 1);
      tmode_reg  <= 1'b0;
      wdog_reg   <= '0;
      gnt_reg    <= '0;
      busreq_reg <= 1'b0;
      busy_reg   <= 1'b0;
      terr_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      last_reg   <= last_next;
      tmode_reg  <= tmode_next;
      wdog_reg   <= wdog_next;
      gnt_reg    <= gnt_next;
      busreq_reg <= busreq_next;
      busy_reg   <= busy_next;
      terr_reg   <= terr_next;
    end
  end

  assign gnt         = gnt_reg;
  assign cpu_busreq  = busreq_reg;
  assign busy        = busy_reg;
  assign timeout_err = terr_reg;

endmodule

// File: tb/tb_jtcps_busarb.sv
// Testbench for jtcps_busarb (CH=3, TW=4): a per-cycle vector table plus
// hand-written sequences for round-robin, watchdog and ack-release waits.
module tb_jtcps_busarb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       turbo = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] gnt;
  logic       cpu_busreq;
  logic       cpu_busack = 1'b0;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  jtcps_busarb #(.CH(3), .TW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .turbo       (turbo),
    .req         (req),
    .gnt         (gnt),
    .cpu_busreq  (cpu_busreq),
    .cpu_busack  (cpu_busack),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       t;
    logic       a;
    logic [2:0] q;
    logic [2:0] g;
    logic       br;
    logic       by;
    logic       te;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic t, input logic a, input logic [2:0] q,
                     input logic [2:0] g, input logic br, input logic by, input logic te);
    vec_t v;
    v = '{r, t, a, q, g, br, by, te};
    vq.push_back(v);
  endtask

  // Drive one cycle of inputs at the falling edge, then sample after the rising edge.
  task automatic cyc(input logic r, input logic t, input logic a, input logic [2:0] q);
    @(negedge clk);
    rst = r; turbo = t; cpu_busack = a; req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int order[$];
    int gcnt[3];
    int viol;
    int brcnt;
    logic seen_g;
    logic [2:0] prev_gnt;
    int exp_order[4];

    // rst, turbo, ack, req  ->  gnt, busreq, busy, timeout_err
    add(1,0,0,3'b000, 3'b000,0,0,0);
    add(0,0,0,3'b000, 3'b000,0,0,0);
    // non-turbo single request, ack at cycle 4, grant at cycle 6
    add(0,0,0,3'b001, 3'b000,1,1,0);
    add(0,0,0,3'b001, 3'b000,1,1,0);
    add(0,0,0,3'b001, 3'b000,1,1,0);
    add(0,0,0,3'b001, 3'b000,1,1,0);
    add(0,0,1,3'b001, 3'b000,1,1,0);
    add(0,0,1,3'b001, 3'b001,1,1,0);
    add(0,0,1,3'b001, 3'b001,1,1,0);
    add(0,0,1,3'b000, 3'b000,1,1,0);
    add(0,0,1,3'b000, 3'b000,0,1,0);
    add(0,0,0,3'b000, 3'b000,0,0,0);
    add(0,0,0,3'b000, 3'b000,0,0,0);
    // turbo on channel 1; turbo toggles mid-grant are ignored
    add(0,1,0,3'b010, 3'b000,0,1,0);
    add(0,1,0,3'b010, 3'b010,0,1,0);
    add(0,0,0,3'b010, 3'b010,0,1,0);
    add(0,1,0,3'b010, 3'b010,0,1,0);
    add(0,0,0,3'b000, 3'b000,0,1,0);
    add(0,0,0,3'b000, 3'b000,0,0,0);
    // reset mid-grant of channel 1, then channel 0 wins first
    add(0,1,0,3'b010, 3'b000,0,1,0);
    add(0,1,0,3'b010, 3'b010,0,1,0);
    add(1,1,0,3'b010, 3'b000,0,0,0);
    add(0,0,0,3'b011, 3'b000,1,1,0);
    add(0,0,1,3'b011, 3'b000,1,1,0);
    add(0,0,1,3'b011, 3'b001,1,1,0);
    add(0,0,1,3'b010, 3'b000,1,1,0);
    add(0,0,1,3'b010, 3'b010,1,1,0);
    add(0,0,1,3'b000, 3'b000,1,1,0);
    add(0,0,1,3'b000, 3'b000,0,1,0);
    add(0,0,0,3'b000, 3'b000,0,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].r, vq[i].t, vq[i].a, vq[i].q);
      $display("vec %0d rst=%b turbo=%b ack=%b req=%b -> gnt=%b busreq=%b busy=%b terr=%b",
               i, vq[i].r, vq[i].t, vq[i].a, vq[i].q, gnt, cpu_busreq, busy, timeout_err);
      chk($sformatf("vec%0d", i), {26'd0, gnt, cpu_busreq, busy, timeout_err},
          {26'd0, vq[i].g, vq[i].br, vq[i].by, vq[i].te});
    end

    // Round-robin: all three request; each drops its request for one cycle
    // after four granted cycles. Expect grant order 0,1,2,0.
    cyc(1,0,0,3'b000);
    for (int i = 0; i < 3; i++) gcnt[i] = 0;
    viol = 0;
    prev_gnt = '0;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      logic [2:0] q;
      for (int i = 0; i < 3; i++) q[i] = (gcnt[i] == 4) ? 1'b0 : 1'b1;
      cyc(0,0,1,q);
      for (int i = 0; i < 3; i++) gcnt[i] = gnt[i] ? gcnt[i] + 1 : 0;
      if (gnt != 3'b000 && prev_gnt == 3'b000) begin
        for (int i = 0; i < 3; i++) if (gnt[i]) order.push_back(i);
      end
      if (gnt != 3'b000 && prev_gnt != 3'b000 && gnt != prev_gnt) viol++;
      if ($countones(gnt) > 1) viol++;
      if (order.size() >= 1 && !cpu_busreq) viol++;
      prev_gnt = gnt;
    end
    $display("round-robin grants observed: %0d", order.size());
    exp_order = '{0, 1, 2, 0};
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_order%0d", k), (order.size() > k) ? order[k] : -1, exp_order[k]);
    chk("rr_gap_onehot_busreq", viol, 0);

    // Watchdog: ack never arrives; timeout after 15 REQ cycles, no grant.
    cyc(1,0,0,3'b000);
    brcnt = 0;
    seen_g = 1'b0;
    for (int c = 0; c < 40 && !timeout_err; c++) begin
      cyc(0,0,0,3'b001);
      if (cpu_busreq) brcnt++;
      if (gnt != 3'b000) seen_g = 1'b1;
    end
    $display("watchdog: busreq high for %0d cycles, terr=%b", brcnt, timeout_err);
    chk("wd_terr", timeout_err, 1);
    chk("wd_req_cycles", brcnt, 15);
    chk("wd_busreq_drop", cpu_busreq, 0);
    chk("wd_no_gnt", seen_g, 0);
    for (int c = 0; c < 3; c++) cyc(0,0,0,3'b000);
    chk("wd_sticky", timeout_err, 1);
    cyc(1,0,0,3'b000);
    chk("wd_rst_clear", timeout_err, 0);

    // Ack-release wait: CPU holds ack after the bus is returned.
    cyc(0,0,1,3'b001);
    chk("ar_busreq", cpu_busreq, 1);
    cyc(0,0,1,3'b001);
    cyc(0,0,1,3'b001);
    chk("ar_gnt", gnt, 3'b001);
    cyc(0,0,1,3'b000);
    cyc(0,0,1,3'b000);
    chk("ar_release", {busy, cpu_busreq}, 2'b10);
    for (int c = 0; c < 3; c++) begin
      cyc(0,0,1,3'b100);
      $display("ack-hold %0d: gnt=%b busreq=%b busy=%b", c, gnt, cpu_busreq, busy);
      chk($sformatf("ar_hold%0d", c), {gnt, cpu_busreq, busy}, {3'b000, 1'b0, 1'b1});
    end
    cyc(0,0,0,3'b100);
    chk("ar_idle", {busy, cpu_busreq}, 2'b00);
    cyc(0,0,0,3'b100);
    chk("ar_rereq", {busy, cpu_busreq}, 2'b11);
    cyc(0,0,1,3'b100);
    cyc(0,0,1,3'b100);
    chk("ar_gnt2", gnt, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtcps_busarb.md
# jtcps_busarb

Parametrised bus-sharing arbiter that sits between the CPS video/DMA requesters and the 68000 bus-request pins in the game top level. It generalises the single busreq/busack pair with a fixed turbo override: it serves CH DMA requesters round-robin, handshakes bus ownership with the main CPU, and bypasses the CPU handshake in turbo mode. A watchdog flags a CPU that never acknowledges.

## Interface
- CH, 2, number of DMA requesters (1..8)
- TW, 10, watchdog counter width in bits (4..16); the timeout fires after 2^TW-1 cycles
---
- clk  in  1  system clock (48 MHz CPU domain)
- rst  in  1  synchronous, active-high reset
- turbo  in  1  when 1, bus is granted without the CPU handshake; sampled only in IDLE
- req  in  CH  per-requester bus request, level, held until the requester is done
- gnt  out  CH  one-hot grant; at most one bit set
- cpu_busreq  out  1  bus request to the main CPU
- cpu_busack  in  1  bus acknowledge from the main CPU
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  sticky watchdog flag, cleared only by rst

## Operation
- States: IDLE, REQ, GRANT, GAP, RELEASE. A 2-bit or 3-bit state register; a pointer register last of width max(1,$clog2(CH)); a mode register tmode; a counter wdog of TW bits.
- Reset: state=IDLE, gnt=0, cpu_busreq=0, busy=0, timeout_err=0, wdog=0, tmode=0, last=CH-1 (so channel 0 wins first).
- IDLE, with any req set and turbo=1: tmode<=1, go to GAP. Channel selection happens in GAP.
- IDLE, with any req set and turbo=0: tmode<=0, cpu_busreq<=1, go to REQ.
- REQ: wdog increments each cycle.
  - If cpu_busack=1, clear wdog and go to GAP.
  - Else, if wdog reaches 2^TW-1: set timeout_err, set cpu_busreq<=0, clear wdog, go to RELEASE.
- GAP: gnt=0.
  - If any req is set, the winner is the first set req index searching from last+1 upward, wrapping modulo CH. Set gnt[winner]<=1, last<=winner, go to GRANT.
  - If no req is set: in tmode, go to IDLE; otherwise set cpu_busreq<=0 and go to RELEASE.
- GRANT: hold gnt while req[last]=1. When req[last]=0, set gnt<=0 and go to GAP. Other requests do not preempt the current grant.
- RELEASE: cpu_busreq=0. Wait for cpu_busack=0, then go to IDLE. This state is never entered in tmode.
- cpu_busreq stays high from REQ through GRANT/GAP until RELEASE. Consecutive grants under one CPU ownership do not re-handshake.
- A change on turbo while busy has no effect until the next IDLE.
- CH=1: the pointer is a 1-bit constant 0 and round-robin degenerates to a fixed grant.
- A req that drops before its grant is simply skipped in GAP. A req that drops in the same cycle as the grant is issued is granted once for one cycle, then released.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Non-turbo: req rises at cycle 0. cpu_busreq=1 at cycle 1. If ack is sampled at cycle k, gnt appears at cycle k+2 (k+1 GAP, k+2 GRANT). Minimum req-to-gnt latency is 3 cycles.
- Turbo: req at cycle 0, GAP at cycle 1, gnt at cycle 2.
- Grant release: req[last] falls at cycle n, gnt=0 at cycle n+1. The next grant is at cycle n+2 at the earliest, so there is always at least one idle gnt cycle between owners.
- Bus return: cpu_busreq falls one cycle after the GAP that found no requests.
- Watchdog: timeout_err rises at the 2^TW-1-th REQ cycle without ack.
- rst asserted in any state returns all outputs to their reset values on the next edge, including mid-GRANT and mid-RELEASE.

## Test plan
- Reset mid-GRANT (CH=2, channel 1 granted): assert rst for 1 cycle -> next edge gnt=0, cpu_busreq=0, busy=0, state IDLE; then req=2'b11 -> channel 0 is granted first.
- Non-turbo single request: req[0]=1 at cycle 0, busack returns at cycle 4 -> cpu_busreq=1 at cycle 1, gnt=01 at cycle 6; drop req -> gnt=0 next cycle, cpu_busreq=0 the cycle after.
- Round-robin (CH=3): hold req=3'b111, each requester releases 4 cycles after being granted -> grants ordered 0,1,2,0; each separated by one gnt=0 cycle; cpu_busreq stays high throughout.
- Turbo: turbo=1, req[1]=1 -> gnt=10 two cycles later; cpu_busreq stays 0 for the whole transaction; toggling turbo during GRANT has no effect.
- Watchdog (TW=4): busack held 0 -> timeout_err=1 after 15 REQ cycles, cpu_busreq drops, no gnt is issued; timeout_err remains 1 until rst.
- Ack-release wait: after the last grant, keep busack=1 for 3 cycles -> busy stays 1 and a new req is not served until busack=0 and IDLE is re-entered.
